// File: rtl/sipo_rx_if.sv
// Serial receive link bundle: serial/control inputs toward sipo_rx and its parallel word outputs.
interface sipo_rx_if #(
    parameter int unsigned WIDTH = 4
);
    logic             si;
    logic             shift;
    logic             clear;
    logic             out_ack;
    logic [WIDTH-1:0] po;
    logic             out_valid;
    logic             busy;
    logic             overrun;

    // Driver of the serial wire and consumer of the parallel word.
    modport master (
        output si, shift, clear, out_ack,
        input  po, out_valid, busy, overrun
    );

    // The receiver itself.
    modport slave (
        input  si, shift, clear, out_ack,
        output po, out_valid, busy, overrun
    );
endinterface

// File: rtl/sipo_rx.sv
// Serial-in, parallel-out receiver: frames MSB-first words by bit count and hands each
// completed word to a holding register with valid/ack handshake and sticky overrun flag.
module sipo_rx #(
    parameter int unsigned WIDTH = 4
) (
    input  logic     clk,
    input  logic     reset,
    sipo_rx_if.slave bus
);
    localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    logic [WIDTH-1:0] sr_q, sr_d;
    logic [WIDTH-1:0] po_q, po_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;
    logic [WIDTH-1:0] word_c;
    logic             done_c;

    // State registers; reset overrides all other inputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q      <= '0;
            cnt_q     <= '0;
            po_q      <= '0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            cnt_q     <= cnt_d;
            po_q      <= po_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    // Next state: clear beats shift; ack is honoured regardless of clear.
    always_comb begin
        sr_d      = sr_q;
        cnt_d     = cnt_q;
        po_d      = po_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        word_c    = {sr_q[WIDTH-2:0], bus.si};
        done_c    = 1'b0;

        if (bus.clear) begin
            sr_d      = '0;
            cnt_d     = '0;
            overrun_d = 1'b0;
        end else if (bus.shift) begin
            sr_d = word_c;
            if (cnt_q == CNT_LAST) begin
                cnt_d  = '0;
                done_c = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        // A completion coinciding with ack is a load, not an overrun.
        if (done_c) begin
            if (!valid_q || bus.out_ack) begin
                po_d    = word_c;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (bus.out_ack && valid_q) begin
            valid_d = 1'b0;
        end
    end

    assign bus.po        = po_q;
    assign bus.out_valid = valid_q;
    assign bus.overrun   = overrun_q;
    assign bus.busy      = (cnt_q != '0);
endmodule

// File: tb/tb_sipo_rx.sv
// Directed self-checking bench for sipo_rx (WIDTH=4): vector table plus multi-cycle sequences.
module tb_sipo_rx;
    localparam int unsigned WIDTH = 4;

    typedef struct packed {
        logic       rst;
        logic       clr;
        logic       sh;
        logic       si;
        logic       ack;
        logic [3:0] po;
        logic       v;
        logic       b;
        logic       ov;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    sipo_rx_if #(.WIDTH(WIDTH)) bus ();
    sipo_rx #(.WIDTH(WIDTH)) dut (.clk(clk), .reset(reset), .bus(bus));

    function automatic vec_t mk(logic rst, logic clr, logic sh, logic si, logic ack,
                                logic [3:0] po, logic v, logic b, logic ov);
        vec_t r;
        r.rst = rst; r.clr = clr; r.sh = sh; r.si = si; r.ack = ack;
        r.po = po; r.v = v; r.b = b; r.ov = ov;
        return r;
    endfunction

    task automatic step(input logic rst, input logic clr, input logic sh,
                        input logic si, input logic ack);
        reset       = rst;
        bus.clear   = clr;
        bus.shift   = sh;
        bus.si      = si;
        bus.out_ack = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] po, input logic v,
                         input logic b, input logic ov);
        n_tests++;
        if (bus.po !== po || bus.out_valid !== v || bus.busy !== b || bus.overrun !== ov) begin
            n_fail++;
            $display("FAIL %s: got po=%b v=%b busy=%b ov=%b, expected po=%b v=%b busy=%b ov=%b",
                     name, bus.po, bus.out_valid, bus.busy, bus.overrun, po, v, b, ov);
        end
    endtask

    initial begin
        logic       bits[4];
        logic [3:0] bb_po[8];
        logic       bb_v[8];
        logic       bb_b[8];
        logic       bb_ack[8];
        logic       bb_si[8];

        reset = 1'b0; bus.clear = 1'b0; bus.shift = 1'b0; bus.si = 1'b0; bus.out_ack = 1'b0;

        //               rst clr sh si ack   po     v  b  ov
        vecs.push_back(mk(1, 0, 0, 0, 0, 4'b0000, 0, 0, 0)); // 0 reset
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'b0000, 0, 1, 0)); // 1 load 1011
        vecs.push_back(mk(0, 0, 1, 0, 0, 4'b0000, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'b0000, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'b1011, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 4'b1011, 1, 1, 0)); // 5 overrun with 0001
        vecs.push_back(mk(0, 0, 1, 0, 0, 4'b1011, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 4'b1011, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'b1011, 1, 0, 1));
        vecs.push_back(mk(0, 1, 0, 0, 0, 4'b1011, 1, 0, 0)); // 9 clear drops overrun
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'b1011, 1, 1, 0)); // 10 same-edge ack, 1100
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'b1011, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 4'b1011, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 1, 4'b1100, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 4'b1100, 0, 0, 0)); // 14 ack drains
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'b1100, 0, 1, 0)); // 15 clear mid-word
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'b1100, 0, 1, 0));
        vecs.push_back(mk(0, 1, 1, 1, 0, 4'b1100, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 4'b1100, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'b1100, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 4'b1100, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'b0101, 1, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'b0101, 1, 1, 0)); // 22 reset mid-word
        vecs.push_back(mk(1, 0, 1, 1, 1, 4'b0000, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'b0000, 0, 1, 0)); // 24 word 1111
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'b0000, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'b0000, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'b1111, 1, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 1, 4'b1111, 0, 0, 0)); // 28 ack, then idle ack ignored
        vecs.push_back(mk(0, 0, 0, 0, 1, 4'b1111, 0, 0, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'b1111, 0, 1, 0)); // 30 word 1010
        vecs.push_back(mk(0, 0, 1, 0, 0, 4'b1111, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 4'b1111, 0, 1, 0));
        vecs.push_back(mk(0, 0, 1, 0, 0, 4'b1010, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 1, 1, 4'b1010, 0, 0, 0)); // 34 clear still honours ack

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].clr, vecs[i].sh, vecs[i].si, vecs[i].ack);
            check($sformatf("vec%0d", i), vecs[i].po, vecs[i].v, vecs[i].b, vecs[i].ov);
        end

        // Stretched timing: bits 0,1,1,0 with 3-cycle shift=0 gaps carrying junk on si.
        bits = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 1'b1, bits[i], 1'b0);
            if (i < 3) begin
                check($sformatf("stretch_bit%0d", i), 4'b1010, 1'b0, 1'b1, 1'b0);
                for (int g = 0; g < 3; g++) begin
                    step(1'b0, 1'b0, 1'b0, ~bits[i], 1'b0);
                    check($sformatf("stretch_gap%0d_%0d", i, g), 4'b1010, 1'b0, 1'b1, 1'b0);
                end
            end
        end
        check("stretch_word", 4'b0110, 1'b1, 1'b0, 1'b0);

        // Back-to-back words 1001, 0110 with shift held high and timely acks.
        bb_si  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        bb_ack = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        bb_po  = '{4'b0110, 4'b0110, 4'b0110, 4'b1001, 4'b1001, 4'b1001, 4'b1001, 4'b0110};
        bb_v   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        bb_b   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int k = 0; k < 8; k++) begin
            step(1'b0, 1'b0, 1'b1, bb_si[k], bb_ack[k]);
            check($sformatf("b2b%0d", k), bb_po[k], bb_v[k], bb_b[k], 1'b0);
        end

        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
